// File: rtl/reg_bank_rr_arb_if.sv
// Bus bundle between config/control masters and the shared register bank arbiter.
// Masters drive requests, write payloads and the read address; the bank answers.
interface reg_bank_rr_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ*AW-1:0] waddr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;
  logic               busy;
  logic [NREQ-1:0]    owner;

  modport master (
    output req, lock, waddr, wdata, rd_addr,
    input  gnt, rd_data, busy, owner
  );

  modport slave (
    input  req, lock, waddr, wdata, rd_addr,
    output gnt, rd_data, busy, owner
  );
endinterface

// File: rtl/reg_bank_rr_arb.sv
// Round-robin write arbiter in front of a small reset-to-zero register bank.
// Optional grant locking is built only when RR_ARB_LOCK_EN is defined.
module reg_bank_rr_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_bank_rr_arb_if.slave  bus
);
  localparam int NREG = 1 << AW;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [DW-1:0]   bank [NREG];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic            ptr_load;
  logic [PW-1:0]   rr_idx;
  logic [NREQ-1:0] rr_gnt;
  logic [NREQ-1:0] gnt_int;
  logic [NREQ-1:0] owner;
  logic [AW-1:0]   waddr_sel;
  logic [DW-1:0]   wdata_sel;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i);
    return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Circular priority search beginning at ptr
  always_comb begin
    int idx;
    logic found;
    rr_gnt = '0;
    rr_idx = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found       = 1'b1;
        rr_gnt[idx] = 1'b1;
        rr_idx      = PW'(idx);
      end
    end
  end

`ifdef RR_ARB_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t   state, state_nxt;
  logic [PW-1:0] lock_id, lock_id_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNLOCKED;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  // While locked only the holder can be granted; ptr stays put until release
  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    gnt_int     = rr_gnt;
    ptr_load    = 1'b0;
    ptr_nxt     = ptr_inc(rr_idx);
    case (state)
      UNLOCKED: begin
        if (|rr_gnt) begin
          if (bus.lock[rr_idx]) begin
            state_nxt   = LOCKED;
            lock_id_nxt = rr_idx;
          end else begin
            ptr_load = 1'b1;
          end
        end
      end
      LOCKED: begin
        gnt_int = '0;
        ptr_nxt = ptr_inc(lock_id);
        if (bus.req[lock_id]) begin
          gnt_int[lock_id] = 1'b1;
          if (!bus.lock[lock_id]) begin
            state_nxt = UNLOCKED;
            ptr_load  = 1'b1;
          end
        end else begin
          state_nxt = UNLOCKED;
          ptr_load  = 1'b1;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;

  always_comb begin
    gnt_int  = rr_gnt;
    ptr_load = |rr_gnt;
    ptr_nxt  = ptr_inc(rr_idx);
  end
`endif

  // Steer the granted requester's payload toward the bank
  always_comb begin
    waddr_sel = '0;
    wdata_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_int[i]) begin
        waddr_sel = bus.waddr[i*AW +: AW];
        wdata_sel = bus.wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) bank[r] <= '0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      if (|gnt_int) begin
        bank[waddr_sel] <= wdata_sel;
        owner           <= gnt_int;
      end
      if (ptr_load) ptr <= ptr_nxt;
    end
  end

  assign bus.gnt     = rst_n ? gnt_int : '0;
  assign bus.rd_data = bank[bus.rd_addr];
  assign bus.busy    = |bus.req;
  assign bus.owner   = owner;
endmodule

// File: tb/tb_reg_bank_rr_arb.sv
// Bench for reg_bank_rr_arb: directed scenarios plus randomized traffic against a reference model.
module tb_reg_bank_rr_arb;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int NREG = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bank_rr_arb_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();
  reg_bank_rr_arb #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0]   m_bank [NREG];
  int              m_ptr;
  logic [NREQ-1:0] m_owner;
  bit              m_locked;
  int              m_lock_id;

  logic [AW-1:0] r_addr [NREQ];
  logic [DW-1:0] r_data [NREQ];

  task automatic drive_payload();
    for (int i = 0; i < NREQ; i++) begin
      bus.waddr[i*AW +: AW] = r_addr[i];
      bus.wdata[i*DW +: DW] = r_data[i];
    end
  endtask

  function automatic void m_reset();
    for (int r = 0; r < NREG; r++) m_bank[r] = '0;
    m_ptr     = 0;
    m_owner   = '0;
    m_locked  = 0;
    m_lock_id = 0;
  endfunction

  function automatic int m_winner();
`ifdef RR_ARB_LOCK_EN
    if (m_locked) return bus.req[m_lock_id] ? m_lock_id : -1;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_gnt();
    logic [NREQ-1:0] g;
    int w;
    g = '0;
    w = m_winner();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  // Advance one clock edge and apply the spec's update rules to the model
  task automatic tick(output int w);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit lk;
    a  = '0;
    d  = '0;
    lk = 0;
    w  = m_winner();
    if (w >= 0) begin
      a  = bus.waddr[w*AW +: AW];
      d  = bus.wdata[w*DW +: DW];
      lk = bus.lock[w];
    end
    @(posedge clk);
    if (w >= 0) begin
      m_bank[a] = d;
      m_owner = '0;
      m_owner[w] = 1'b1;
`ifdef RR_ARB_LOCK_EN
      if (m_locked) begin
        if (!lk) begin
          m_locked = 0;
          m_ptr = (w + 1) % NREQ;
        end
      end else if (lk) begin
        m_locked = 1;
        m_lock_id = w;
      end else begin
        m_ptr = (w + 1) % NREQ;
      end
`else
      m_ptr = (w + 1) % NREQ;
`endif
    end else if (m_locked) begin
      m_locked = 0;
      m_ptr = (m_lock_id + 1) % NREQ;
    end
    #1;
  endtask

  task automatic apply_reset();
    int unused_w;
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    bus.lock = '0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    unused_w = 0;
  endtask

  task automatic test_reset();
    bus.req = '1;
    bus.lock = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = AW'(i);
      r_data[i] = 8'hEE;
    end
    drive_payload();
    bus.rd_addr = '0;
    m_reset();
    #2;
    checks++;
    if (bus.gnt !== '0) begin
      failures++;
      $display("FAIL reset_gnt_low got=%b exp=%b", bus.gnt, {NREQ{1'b0}});
    end
    @(posedge clk);
    #1;
    bus.req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int a = 0; a < NREG; a++) begin
      bus.rd_addr = AW'(a);
      #1;
      checks++;
      if (bus.rd_data !== 8'h00) begin
        failures++;
        $display("FAIL reset_rd addr=%0d got=%h exp=00", a, bus.rd_data);
      end
    end
    checks++;
    if (bus.gnt !== '0 || bus.owner !== '0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got gnt=%b owner=%b busy=%b exp all zero", bus.gnt, bus.owner, bus.busy);
    end
  endtask

  task automatic test_single_write();
    int w;
    r_addr[0] = 2'd2;
    r_data[0] = 8'hA5;
    drive_payload();
    bus.req = 4'b0001;
    bus.rd_addr = 2'd2;
    #1;
    checks++;
    if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL single_gnt got gnt=%b busy=%b exp gnt=0001 busy=1", bus.gnt, bus.busy);
    end
    checks++;
    if (bus.rd_data !== 8'h00) begin
      failures++;
      $display("FAIL single_old_rd got=%h exp=00", bus.rd_data);
    end
    tick(w);
    bus.req = '0;
    #1;
    checks++;
    if (bus.owner !== 4'b0001 || bus.rd_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_after got owner=%b rd=%h exp owner=0001 rd=a5", bus.owner, bus.rd_data);
    end
  endtask

  task automatic test_rotation();
    int w;
    logic [NREQ-1:0] exp_seq;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = AW'(i);
      r_data[i] = 8'h10 + 8'(i);
    end
    drive_payload();
    bus.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_seq = '0;
      exp_seq[c % NREQ] = 1'b1;
      checks++;
      if (bus.gnt !== exp_seq || bus.gnt !== m_gnt()) begin
        failures++;
        $display("FAIL rot_gnt cyc=%0d got=%b exp=%b", c, bus.gnt, exp_seq);
      end
      tick(w);
    end
    bus.req = '0;
    for (int a = 0; a < NREG; a++) begin
      bus.rd_addr = AW'(a);
      #1;
      checks++;
      if (bus.rd_data !== 8'h10 + 8'(a)) begin
        failures++;
        $display("FAIL rot_bank addr=%0d got=%h exp=%h", a, bus.rd_data, 8'h10 + 8'(a));
      end
    end
  endtask

  task automatic test_same_addr();
    int w;
    apply_reset();
    r_addr[1] = 2'd1;
    r_data[1] = 8'h5A;
    drive_payload();
    bus.req = 4'b0010;
    tick(w);
    r_addr[1] = 2'd0;
    r_data[1] = 8'h11;
    r_addr[3] = 2'd0;
    r_data[3] = 8'h33;
    drive_payload();
    bus.req = 4'b1010;
    #1;
    checks++;
    if (bus.gnt !== 4'b1000) begin
      failures++;
      $display("FAIL same_first got=%b exp=1000", bus.gnt);
    end
    tick(w);
    bus.req = 4'b0010;
    bus.rd_addr = 2'd0;
    #1;
    checks++;
    if (bus.gnt !== 4'b0010 || bus.rd_data !== 8'h33) begin
      failures++;
      $display("FAIL same_second got gnt=%b rd=%h exp gnt=0010 rd=33", bus.gnt, bus.rd_data);
    end
    tick(w);
    bus.req = '0;
    #1;
    checks++;
    if (bus.rd_data !== 8'h11 || bus.rd_data !== m_bank[0]) begin
      failures++;
      $display("FAIL same_final got=%h exp=11", bus.rd_data);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = AW'(i);
      r_data[i] = 8'hC0 + 8'(i);
    end
    drive_payload();
    bus.req = 4'b1111;
    for (int c = 0; c < 3; c++) tick(w);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (bus.gnt !== '0 || bus.owner !== '0) begin
      failures++;
      $display("FAIL mid_rst_ctrl got gnt=%b owner=%b exp 0", bus.gnt, bus.owner);
    end
    for (int a = 0; a < NREG; a++) begin
      bus.rd_addr = AW'(a);
      #1;
      checks++;
      if (bus.rd_data !== 8'h00) begin
        failures++;
        $display("FAIL mid_rst_bank addr=%0d got=%h exp=00", a, bus.rd_data);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL mid_rst_first got=%b exp=0001", bus.gnt);
    end
    tick(w);
    bus.req = '0;
    #1;
  endtask

  task automatic test_random();
    int w;
    bit pend [NREQ];
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            pend[i] = 1;
            r_addr[i] = AW'($urandom_range(0, NREG - 1));
            r_data[i] = DW'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
        bus.req[i] = pend[i];
        bus.lock[i] = ($urandom_range(0, 2) == 0);
      end
      drive_payload();
      bus.rd_addr = AW'($urandom_range(0, NREG - 1));
      #1;
      checks++;
      if (bus.gnt !== m_gnt() || $countones(bus.gnt) > 1) begin
        failures++;
        $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, bus.gnt, m_gnt());
      end
      checks++;
      if (bus.rd_data !== m_bank[bus.rd_addr] || bus.busy !== (|bus.req)) begin
        failures++;
        $display("FAIL rnd_rd cyc=%0d got rd=%h busy=%b exp rd=%h busy=%b",
                 c, bus.rd_data, bus.busy, m_bank[bus.rd_addr], |bus.req);
      end
      checks++;
      if (bus.owner !== m_owner) begin
        failures++;
        $display("FAIL rnd_owner cyc=%0d got=%b exp=%b", c, bus.owner, m_owner);
      end
      tick(w);
      if (w >= 0) pend[w] = 0;
    end
    bus.req = '0;
    bus.lock = '0;
    #1;
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic test_lock();
    int w;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = AW'(i);
      r_data[i] = 8'h40 + 8'(i);
    end
    drive_payload();
    bus.req = 4'b0010;
    tick(w);
    bus.req = 4'b1111;
    for (int b = 1; b <= 3; b++) begin
      bus.lock = (b < 3) ? 4'b0100 : 4'b0000;
      r_data[2] = 8'h70 + 8'(b);
      drive_payload();
      #1;
      checks++;
      if (bus.gnt !== 4'b0100 || bus.gnt !== m_gnt()) begin
        failures++;
        $display("FAIL lock_beat beat=%0d got=%b exp=0100", b, bus.gnt);
      end
      tick(w);
    end
    bus.lock = '0;
    #1;
    checks++;
    if (bus.gnt !== 4'b1000) begin
      failures++;
      $display("FAIL lock_release got=%b exp=1000", bus.gnt);
    end
    bus.req = '0;
    #1;
  endtask
`endif

  initial begin
    bus.req = '0;
    bus.lock = '0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.rd_addr = '0;
    test_reset();
    test_single_write();
    test_rotation();
    test_same_addr();
    test_reset_mid();
`ifdef RR_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completion");
    $fatal(1, "timeout");
  end
endmodule
